// File: rtl/main_decoder_queue_if.sv
// Handshake/bus bundle for main_decoder_queue: enqueue side, head-entry side, flush and occupancy.
interface main_decoder_queue_if #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [6:0]       op_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [TAG_W-1:0] tag_o;
  logic             reg_write_o;
  logic             alu_src_o;
  logic             mem_write_o;
  logic             width_op_o;
  logic             pc_base_src_o;
  logic [2:0]       imm_src_o;
  logic [2:0]       result_src_o;
  logic [1:0]       alu_op_o;
  logic [1:0]       branch_op_o;
  logic             illegal_o;
  logic [CNT_W-1:0] count_o;

  modport slave (
    input  flush_i, valid_i, op_i, tag_i, ready_i,
    output ready_o, valid_o, tag_o, reg_write_o, alu_src_o, mem_write_o, width_op_o,
           pc_base_src_o, imm_src_o, result_src_o, alu_op_o, branch_op_o, illegal_o, count_o
  );

  modport master (
    output flush_i, valid_i, op_i, tag_i, ready_i,
    input  ready_o, valid_o, tag_o, reg_write_o, alu_src_o, mem_write_o, width_op_o,
           pc_base_src_o, imm_src_o, result_src_o, alu_op_o, branch_op_o, illegal_o, count_o
  );
endinterface

// File: rtl/main_decoder_queue.sv
// Decode-at-enqueue FIFO of main-decoder control words with per-entry tags and registered head outputs.
// Optional macro DECODER_ILLEGAL_CNT_EN adds a saturating illegal-opcode push counter (illegal_cnt_o).
module main_decoder_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  main_decoder_queue_if.slave    bus
`ifdef DECODER_ILLEGAL_CNT_EN
  ,
  output logic [7:0]             illegal_cnt_o
`endif
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [2:0] result_src;
    logic [1:0] branch_op;
    logic [1:0] alu_op;
    logic       width_op;
    logic       pc_base_src;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t            ctrl;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_e;

  function automatic ctrl_t decode(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      7'b0110011: c = ctrl_t'(16'b1_000_0_0_000_00_10_0_0_0);
      7'b0010011: c = ctrl_t'(16'b1_000_1_0_000_00_10_0_0_0);
      7'b0000011: c = ctrl_t'(16'b1_000_1_0_100_00_00_1_0_0);
      7'b0100011: c = ctrl_t'(16'b0_001_1_1_000_00_00_1_0_0);
      7'b1100011: c = ctrl_t'(16'b0_010_0_0_000_11_01_0_0_0);
      7'b1101111: c = ctrl_t'(16'b1_011_0_0_010_01_00_0_0_0);
      7'b1100111: c = ctrl_t'(16'b1_000_0_0_010_01_00_0_1_0);
      7'b0110111: c = ctrl_t'(16'b1_100_0_0_011_00_00_0_0_0);
      7'b0010111: c = ctrl_t'(16'b1_100_0_0_001_00_00_0_0_0);
      default:    c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  occ_e             occ_q, occ_d;
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           head_q, head_d;
  entry_t           mem_q [DEPTH];
  entry_t           new_entry;
  logic             push, pop;

  assign new_entry = '{ctrl: decode(bus.op_i), tag: bus.tag_i};
  assign push      = bus.valid_i && (occ_q != FULL) && !bus.flush_i;
  assign pop       = (occ_q != EMPTY) && bus.ready_i && !bus.flush_i;

  // Next occupancy/pointers; head register is preloaded so outputs stay registered
  always_comb begin
    rd_d   = rd_q + PTR_W'(pop);
    wr_d   = wr_q + PTR_W'(push);
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    occ_d  = PARTIAL;
    head_d = mem_q[rd_d];
    if (bus.flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
    if (cnt_d == '0) begin
      occ_d = EMPTY;
    end else if (cnt_d == CNT_W'(DEPTH)) begin
      occ_d = FULL;
    end
    // Entry being written this edge becomes the head (empty queue, or sole entry popped)
    if (push && (wr_q == rd_d)) begin
      head_d = new_entry;
    end
    if (occ_d == EMPTY) begin
      head_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occ_q  <= EMPTY;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      occ_q  <= occ_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  // Storage array carries no reset; only occupied slots are ever read out
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_q] <= new_entry;
    end
  end

`ifdef DECODER_ILLEGAL_CNT_EN
  logic [7:0] ill_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ill_cnt_q <= '0;
    end else if (push && new_entry.ctrl.illegal && (ill_cnt_q != 8'hFF)) begin
      ill_cnt_q <= ill_cnt_q + 8'd1;
    end
  end

  assign illegal_cnt_o = ill_cnt_q;
`endif

  assign bus.ready_o       = (occ_q != FULL);
  assign bus.valid_o       = (occ_q != EMPTY);
  assign bus.count_o       = cnt_q;
  assign bus.tag_o         = head_q.tag;
  assign bus.reg_write_o   = head_q.ctrl.reg_write;
  assign bus.imm_src_o     = head_q.ctrl.imm_src;
  assign bus.alu_src_o     = head_q.ctrl.alu_src;
  assign bus.mem_write_o   = head_q.ctrl.mem_write;
  assign bus.result_src_o  = head_q.ctrl.result_src;
  assign bus.branch_op_o   = head_q.ctrl.branch_op;
  assign bus.alu_op_o      = head_q.ctrl.alu_op;
  assign bus.width_op_o    = head_q.ctrl.width_op;
  assign bus.pc_base_src_o = head_q.ctrl.pc_base_src;
  assign bus.illegal_o     = head_q.ctrl.illegal;
endmodule
